// File: rtl/cordic_angle_sequencer_if.sv
// Request, CORDIC-core and result signals between the angle sequencer and its neighbours.
// The slave modport is the sequencer's view; master is the requester/core/consumer side.
interface cordic_angle_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_angle;
    logic       core_reset;
    logic [5:0] core_z;
    logic       core_done;
    logic [5:0] core_x;
    logic [5:0] core_y;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_cos;
    logic [5:0] out_sin;
    logic       out_err;

    modport slave (
        input  in_valid, in_angle, core_done, core_x, core_y, out_ready,
        output in_ready, core_reset, core_z, out_valid, out_cos, out_sin, out_err
    );

    modport master (
        output in_valid, in_angle, core_done, core_x, core_y, out_ready,
        input  in_ready, core_reset, core_z, out_valid, out_cos, out_sin, out_err
    );
endinterface

// File: rtl/cordic_angle_sequencer.sv
// Folds a full-circle angle into the CORDIC core's +/-90 deg range, sequences the core and
// unfolds its result. Define CORDIC_SEQ_TIMEOUT_EN to abort a RUN after 15 cycles without core_done.
//
// state | meaning
// IDLE  | core parked, waiting for a request
// LOAD  | two cycles presenting core_z with the core held in reset
// RUN   | core released, waiting for core_done
// OUT   | result presented until the consumer accepts it
module cordic_angle_sequencer (
    input  logic                     clk,
    input  logic                     reset,
    cordic_angle_sequencer_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]        state;
    logic [5:0]        z_q;
    logic              flip_q;
    logic              load_cnt;
    logic [5:0]        cos_q;
    logic [5:0]        sin_q;
    logic              err_q;
`ifdef CORDIC_SEQ_TIMEOUT_EN
    logic [3:0]        tmo_cnt;
`endif

    logic signed [6:0] angle_s;
    logic signed [6:0] fold_sum;
    logic              fold_flip;
    logic              in_range;

    // 62 LSB is 180 deg: folding by it negates both cosine and sine.
    always_comb begin
        angle_s   = signed'(bus.in_angle);
        in_range  = (angle_s >= -7'sd62) && (angle_s <= 7'sd62);
        fold_sum  = angle_s;
        fold_flip = 1'b0;
        if (angle_s > 7'sd31) begin
            fold_sum  = angle_s - 7'sd62;
            fold_flip = 1'b1;
        end else if (angle_s < -7'sd31) begin
            fold_sum  = angle_s + 7'sd62;
            fold_flip = 1'b1;
        end
    end

    // -(-32) does not fit in 6 bits, so it saturates to +31.
    function automatic logic [5:0] neg_sat(input logic [5:0] v);
        if (v == 6'b100000)
            return 6'b011111;
        return ~v + 6'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            z_q      <= 6'd0;
            flip_q   <= 1'b0;
            load_cnt <= 1'b0;
            cos_q    <= 6'd0;
            sin_q    <= 6'd0;
            err_q    <= 1'b0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            tmo_cnt  <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (in_range) begin
                            z_q      <= fold_sum[5:0];
                            flip_q   <= fold_flip;
                            load_cnt <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            cos_q <= 6'd0;
                            sin_q <= 6'd0;
                            err_q <= 1'b1;
                            state <= OUT;
                        end
                    end
                end
                LOAD: begin
                    if (load_cnt == 1'b0) begin
                        state   <= RUN;
`ifdef CORDIC_SEQ_TIMEOUT_EN
                        tmo_cnt <= 4'd14;
`endif
                    end else begin
                        load_cnt <= load_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (bus.core_done) begin
                        cos_q <= flip_q ? neg_sat(bus.core_x) : bus.core_x;
                        sin_q <= flip_q ? neg_sat(bus.core_y) : bus.core_y;
                        err_q <= 1'b0;
                        state <= OUT;
                    end
`ifdef CORDIC_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == 4'd0) begin
                        cos_q <= 6'd0;
                        sin_q <= 6'd0;
                        err_q <= 1'b1;
                        state <= OUT;
                    end else begin
                        tmo_cnt <= tmo_cnt - 4'd1;
                    end
`endif
                end
                OUT: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == OUT);
    assign bus.core_reset = (state != RUN);
    assign bus.core_z     = ((state == LOAD) || (state == RUN)) ? z_q : 6'd0;
    assign bus.out_cos    = cos_q;
    assign bus.out_sin    = sin_q;
    assign bus.out_err    = err_q;
endmodule
